// File: rtl/mlp_pkg.sv
// Shared constants and types for the MLP result drain: frame geometry, element/row types
// and the drain FSM state encoding.
package mlp_pkg;

    localparam int DW         = 16;
    localparam int COL        = 16;
    localparam int ROW        = 2;
    localparam int ROWS_TOTAL = 16;
    localparam int OUT_W      = 32;

    localparam int NUM_ROUNDS    = ROWS_TOTAL / ROW;
    localparam int NUM_WORDS     = ROWS_TOTAL * COL * DW / OUT_W;
    localparam int WORDS_PER_ROW = COL / 2;

    localparam int ROUND_W = $clog2(NUM_ROUNDS);
    localparam int CNT_W   = $clog2(NUM_WORDS);
    localparam int RIDX_W  = $clog2(ROWS_TOTAL);
    localparam int EIDX_W  = $clog2(COL);

    typedef logic [DW-1:0]   elem_t;
    typedef elem_t [COL-1:0] row_t;

    typedef enum logic {
        COLLECT,
        DRAIN
    } drain_state_e;

    // An output word carries two neighbouring elements, the lower column in the low half.
    function automatic logic [OUT_W-1:0] pair_word(input row_t row, input int c);
        return {row[EIDX_W'(c + 1)], row[EIDX_W'(c)]};
    endfunction

endpackage

// File: rtl/mlp_result_drain.sv
// Collects rounded result rows into a full frame, then streams the frame out as
// two-element words over a valid/ready port.
module mlp_result_drain
    import mlp_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     round_valid_i,
    input  logic [ROUND_W-1:0]       round_number_i,
    input  logic [ROW*COL*DW-1:0]    round_data_i,
    input  logic                     result_ready_i,
    output logic                     result_valid_o,
    output logic [OUT_W-1:0]         result_payload_o,
    output logic                     busy_o,
    output logic                     frame_done_o,
    output logic                     overflow_o
);

    drain_state_e          state;
    logic [NUM_ROUNDS-1:0] mask;
    logic [NUM_ROUNDS-1:0] mask_next;
    logic [CNT_W-1:0]      word_cnt;
    row_t                  mem [ROWS_TOTAL];
    row_t                  in_rows [ROW];

    logic                  transfer;
    logic                  last_transfer;
    logic                  accept;
    logic [OUT_W-1:0]      first_word;
    logic [OUT_W-1:0]      next_word;
    int                    next_k;

    // The exit cycle already belongs to the next frame, so a round arriving then starts a fresh mask.
    always_comb begin
        transfer      = (state == DRAIN) && result_valid_o && result_ready_i;
        last_transfer = transfer && (word_cnt == CNT_W'(NUM_WORDS - 1));
        accept        = round_valid_i && ((state == COLLECT) || last_transfer);
        mask_next     = (last_transfer ? '0 : mask) | (NUM_ROUNDS'(1) << round_number_i);

        for (int r = 0; r < ROW; r++) begin
            in_rows[r] = round_data_i[r*COL*DW +: COL*DW];
        end

        // Word 0 must be ready the cycle after the completing round, which may itself carry row 0.
        first_word = pair_word((round_number_i == '0) ? in_rows[0] : mem[0], 0);

        next_k    = int'(word_cnt) + 1;
        next_word = pair_word(mem[RIDX_W'(next_k / WORDS_PER_ROW)],
                              2 * (next_k % WORDS_PER_ROW));
    end

    always_ff @(posedge clk) begin
        if (rst_n && accept) begin
            for (int r = 0; r < ROW; r++) begin
                mem[RIDX_W'(int'(round_number_i) * ROW + r)] <= in_rows[r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= COLLECT;
            mask             <= '0;
            word_cnt         <= '0;
            result_valid_o   <= 1'b0;
            result_payload_o <= '0;
            busy_o           <= 1'b0;
            frame_done_o     <= 1'b0;
            overflow_o       <= 1'b0;
        end else begin
            frame_done_o <= 1'b0;
            case (state)
                COLLECT: begin
                    if (accept) begin
                        mask <= mask_next;
                        if (&mask_next) begin
                            state            <= DRAIN;
                            busy_o           <= 1'b1;
                            result_valid_o   <= 1'b1;
                            result_payload_o <= first_word;
                            word_cnt         <= '0;
                        end
                    end
                end
                DRAIN: begin
                    if (round_valid_i && !last_transfer) begin
                        overflow_o <= 1'b1;
                    end
                    if (last_transfer) begin
                        state          <= COLLECT;
                        busy_o         <= 1'b0;
                        result_valid_o <= 1'b0;
                        word_cnt       <= '0;
                        frame_done_o   <= 1'b1;
                        mask           <= accept ? mask_next : '0;
                    end else if (transfer) begin
                        word_cnt         <= word_cnt + CNT_W'(1);
                        result_payload_o <= next_word;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_mlp_result_drain.sv
// Self-checking bench for mlp_result_drain: directed frames with random data, checked
// against a matrix model of the collected frame and the word ordering rule.
module tb_mlp_result_drain;
    import mlp_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  round_valid_i;
    logic [ROUND_W-1:0]    round_number_i;
    logic [ROW*COL*DW-1:0] round_data_i;
    logic                  result_ready_i;
    logic                  result_valid_o;
    logic [OUT_W-1:0]      result_payload_o;
    logic                  busy_o;
    logic                  frame_done_o;
    logic                  overflow_o;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0]         src [ROWS_TOTAL][COL];
    logic [DW-1:0]         mat [ROWS_TOTAL][COL];
    logic [NUM_ROUNDS-1:0] model_mask;
    bit                    model_ovf;
    logic [OUT_W-1:0]      lit_words [int];

    always #5 clk = ~clk;

    mlp_result_drain dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .round_valid_i    (round_valid_i),
        .round_number_i   (round_number_i),
        .round_data_i     (round_data_i),
        .result_ready_i   (result_ready_i),
        .result_valid_o   (result_valid_o),
        .result_payload_o (result_payload_o),
        .busy_o           (busy_o),
        .frame_done_o     (frame_done_o),
        .overflow_o       (overflow_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [OUT_W-1:0] obs,
                                input logic [OUT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [OUT_W-1:0] expected_word(input int k);
        int r = k / (COL / 2);
        int c = 2 * (k % (COL / 2));
        return {mat[r][c+1], mat[r][c]};
    endfunction

    function automatic logic [ROW*COL*DW-1:0] pack_round(input int rn);
        logic [ROW*COL*DW-1:0] d = '0;
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                d[(r*COL+c)*DW +: DW] = src[rn*ROW+r][c];
        return d;
    endfunction

    task automatic update_model(input int rn);
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                mat[rn*ROW+r][c] = src[rn*ROW+r][c];
        model_mask[rn] = 1'b1;
    endtask

    task automatic fill_src(input bit random_data);
        for (int r = 0; r < ROWS_TOTAL; r++)
            for (int c = 0; c < COL; c++)
                src[r][c] = random_data ? DW'($urandom) : DW'(r * 256 + c);
    endtask

    // Sends one round and checks that draining starts exactly when every round has been seen.
    task automatic apply_stimulus(input int rn);
        round_valid_i  = 1'b1;
        round_number_i = ROUND_W'(rn);
        round_data_i   = pack_round(rn);
        tick();
        round_valid_i  = 1'b0;
        update_model(rn);
        check_output("overflow_collect", overflow_o, model_ovf);
        if (&model_mask) begin
            check_output("valid_after_last_round", result_valid_o, 1);
            check_output("busy_after_last_round", busy_o, 1);
            check_output("first_word", result_payload_o, expected_word(0));
        end else begin
            check_output("valid_while_collecting", result_valid_o, 0);
            check_output("busy_while_collecting", busy_o, 0);
        end
    endtask

    task automatic reset_dut();
        rst_n          = 1'b0;
        round_valid_i  = 1'b0;
        round_number_i = '0;
        round_data_i   = '0;
        result_ready_i = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        model_mask = '0;
        model_ovf  = 1'b0;
        check_output("reset_valid", result_valid_o, 0);
        check_output("reset_payload", result_payload_o, 0);
        check_output("reset_busy", busy_o, 0);
        check_output("reset_done", frame_done_o, 0);
        check_output("reset_overflow", overflow_o, 0);
    endtask

    // ready_mode: 0 always ready, 1 repeating 1-0-0-1, 2 random.
    task automatic drain_frame(input int ready_mode, input int inject_at, input int abort_at,
                               input bit feed_next);
        int k = 0;
        int cyc = 0;
        bit rdy;
        bit injected = 1'b0;
        while (k < NUM_WORDS && cyc < 1000) begin
            case (ready_mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            result_ready_i = rdy;
            check_output("drain_valid", result_valid_o, 1);
            check_output("drain_payload", result_payload_o, expected_word(k));
            if (lit_words.exists(k))
                check_output("literal_word", result_payload_o, lit_words[k]);
            if (k == abort_at) begin
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                result_ready_i = 1'b1;
                model_mask = '0;
                model_ovf  = 1'b0;
                lit_words.delete();
                check_output("abort_valid", result_valid_o, 0);
                check_output("abort_busy", busy_o, 0);
                check_output("abort_overflow", overflow_o, 0);
                return;
            end
            if (k == inject_at && rdy && !injected) begin
                round_valid_i  = 1'b1;
                round_number_i = ROUND_W'($urandom_range(5, NUM_ROUNDS - 1));
                round_data_i   = {16{$urandom()}};
                injected  = 1'b1;
                model_ovf = 1'b1;
            end
            if (k == NUM_WORDS - 1 && rdy && feed_next) begin
                round_valid_i  = 1'b1;
                round_number_i = '0;
                round_data_i   = pack_round(0);
            end
            tick();
            round_valid_i = 1'b0;
            cyc++;
            if (rdy) k++;
        end
        if (k != NUM_WORDS)
            check_output("drain_timeout", OUT_W'(k), OUT_W'(NUM_WORDS));
        result_ready_i = 1'b1;
        model_mask = '0;
        if (feed_next) update_model(0);
        lit_words.delete();
        check_output("exit_valid", result_valid_o, 0);
        check_output("exit_done", frame_done_o, 1);
        check_output("exit_busy", busy_o, 0);
        check_output("exit_overflow", overflow_o, model_ovf);
        tick();
        check_output("done_pulse_len", frame_done_o, 0);
        check_output("idle_valid", result_valid_o, 0);
    endtask

    initial begin
        reset_dut();

        // Counting pattern, rounds in order.
        fill_src(1'b0);
        for (int rn = 0; rn < NUM_ROUNDS; rn++) apply_stimulus(rn);
        lit_words[0]   = 32'h0001_0000;
        lit_words[8]   = 32'h0101_0100;
        lit_words[127] = 32'h0F0F_0F0E;
        drain_frame(0, -1, -1, 1'b0);

        // Scrambled order with a duplicate round overwriting rows 6 and 7.
        fill_src(1'b0);
        apply_stimulus(7);
        apply_stimulus(3);
        apply_stimulus(0);
        apply_stimulus(5);
        apply_stimulus(1);
        for (int c = 0; c < COL; c++) begin
            src[6][c] = 16'hFFFF;
            src[7][c] = 16'hFFFF;
        end
        apply_stimulus(3);
        apply_stimulus(6);
        apply_stimulus(2);
        apply_stimulus(4);
        lit_words[48] = 32'hFFFF_FFFF;
        lit_words[63] = 32'hFFFF_FFFF;
        drain_frame(0, -1, -1, 1'b0);

        // Back-pressure with ready toggling 1-0-0-1.
        fill_src(1'b1);
        for (int rn = 0; rn < NUM_ROUNDS; rn++) apply_stimulus(rn);
        drain_frame(1, -1, -1, 1'b0);

        // Stray round during drain, then a normal frame ending on round 0.
        fill_src(1'b1);
        for (int rn = 0; rn < NUM_ROUNDS; rn++) apply_stimulus(rn);
        drain_frame(0, 40, -1, 1'b0);
        fill_src(1'b1);
        for (int rn = NUM_ROUNDS - 1; rn >= 0; rn--) apply_stimulus(rn);
        drain_frame(2, -1, -1, 1'b0);

        // Reset in the middle of a drain, then a fresh frame.
        fill_src(1'b1);
        for (int rn = 0; rn < NUM_ROUNDS; rn++) apply_stimulus(rn);
        drain_frame(0, -1, 60, 1'b0);
        fill_src(1'b1);
        for (int rn = 0; rn < NUM_ROUNDS; rn++) apply_stimulus(rn);
        drain_frame(0, -1, -1, 1'b0);

        // Back-to-back frames: round 0 of the second frame lands in the exit cycle.
        fill_src(1'b1);
        for (int rn = 0; rn < NUM_ROUNDS; rn++) apply_stimulus(rn);
        fill_src(1'b1);
        drain_frame(0, -1, -1, 1'b1);
        for (int rn = 1; rn < NUM_ROUNDS; rn++) apply_stimulus(rn);
        drain_frame(2, -1, -1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
